// File: rtl/raven_dac_streamer_pkg.sv
// Shared definitions for the Raven DAC sample streamer.
// Contents:
//   - reg_sel_e       : register select decoded from iomem_addr[3:2]
//   - CTRL_* / STAT_* : bit positions inside the CTRL and STAT registers
//   - DAC_BITS_DEF    : default DAC code width
//   - count_at_or_below() : FIFO-low comparison used for irq_low
package raven_dac_streamer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_DIV  = 2'd1,
        REG_DATA = 2'd2,
        REG_STAT = 2'd3
    } reg_sel_e;

    // CTRL register fields
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_ENA     = 2;
    localparam int CTRL_THR_LSB = 8;
    localparam int THR_W        = 4;

    // STAT register fields
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_UNDERRUN  = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int COUNT_FIELD_W  = 8;

    localparam int DAC_BITS_DEF = 10;

    // True when the FIFO fill level has dropped to the interrupt threshold.
    function automatic logic count_at_or_below(input logic [COUNT_FIELD_W-1:0] cnt,
                                               input logic [THR_W-1:0]         thr);
        return cnt <= {{(COUNT_FIELD_W-THR_W){1'b0}}, thr};
    endfunction

endpackage

// File: rtl/raven_dac_fifo.sv
// Sample FIFO for the Raven DAC streamer.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (pointers only)
//   push_i, wdata_i : write request and sample
//   pop_i           : advance the read pointer (head_o is the current head)
//   flush_i         : empty the FIFO; takes priority over push and pop
//   head_o          : sample at the read pointer
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored samples (0..DEPTH)
// A push while full is accepted only if a pop happens in the same cycle,
// in which case the new sample lands in the slot being vacated.
module raven_dac_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Sample storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/raven_dac_streamer.sv
// Memory-mapped sample streamer feeding the Raven 10-bit DAC.
// The CPU pushes samples over the picorv32 iomem bus; a programmable
// sample-period timer pops one sample per period onto dac_value.
// Ports:
//   clk, reset    : single clock, synchronous active-high reset
//   iomem_valid   : bus request
//   iomem_ready   : one-cycle acknowledge, the cycle after the request is seen
//   iomem_wstrb   : byte strobes, any nonzero value is a full-word write
//   iomem_addr    : byte address, [3:2] selects CTRL/DIV/DATA/STAT
//   iomem_wdata   : write data
//   iomem_rdata   : read data, valid while iomem_ready is high
//   dac_value     : DAC input code
//   dac_ena       : DAC enable (registered copy of CTRL.ena)
//   irq_low       : level interrupt, run && fill level <= threshold
module raven_dac_streamer
    import raven_dac_streamer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DAC_BITS = DAC_BITS_DEF,
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [3:0]          iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    output logic [DAC_BITS-1:0] dac_value,
    output logic                dac_ena,
    output logic                irq_low
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Architectural state
    logic                ready_q,    ready_d;
    logic                run_q,      run_d;
    logic                ena_q,      ena_d;
    logic [THR_W-1:0]    thr_q,      thr_d;
    logic [DIV_BITS-1:0] div_q,      div_d;
    logic [DIV_BITS-1:0] cnt_q,      cnt_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic [DAC_BITS-1:0] dac_q,      dac_d;
    logic                dac_ena_q,  dac_ena_d;
    logic                irq_q,      irq_d;

    // Decode and datapath wires
    reg_sel_e            reg_sel;
    logic                ack_wr;
    logic                wr_ctrl, wr_div, wr_data, wr_stat;
    logic                flush;
    logic                tick;
    logic                pop;
    logic [DAC_BITS-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [COUNT_FIELD_W-1:0] count_ext;
    logic [31:0]         rdata_mux;
    logic                unused_bits;

    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata};

    assign reg_sel = reg_sel_e'(iomem_addr[3:2]);

    // Writes commit at the end of the acknowledge cycle.
    assign ack_wr  = ready_q && iomem_valid && (iomem_wstrb != 4'b0000);
    assign wr_ctrl = ack_wr && (reg_sel == REG_CTRL);
    assign wr_div  = ack_wr && (reg_sel == REG_DIV);
    assign wr_data = ack_wr && (reg_sel == REG_DATA);
    assign wr_stat = ack_wr && (reg_sel == REG_STAT);

    assign flush = wr_ctrl && iomem_wdata[CTRL_FLUSH];
    assign tick  = run_q && (cnt_q == '0);
    // A same-cycle flush cancels the pop, so dac_value keeps its old code.
    assign pop   = tick && !fifo_empty && !flush;

    raven_dac_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DAC_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_data),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (iomem_wdata[DAC_BITS-1:0]),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        count_ext = '0;
        count_ext[CW-1:0] = fifo_count;
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata_mux[CTRL_RUN] = run_q;
                rdata_mux[CTRL_ENA] = ena_q;
                rdata_mux[CTRL_THR_LSB +: THR_W] = thr_q;
            end
            REG_DIV:  rdata_mux[DIV_BITS-1:0] = div_q;
            REG_DATA: rdata_mux = '0;
            REG_STAT: begin
                rdata_mux[STAT_EMPTY]    = fifo_empty;
                rdata_mux[STAT_FULL]     = fifo_full;
                rdata_mux[STAT_UNDERRUN] = underrun_q;
                rdata_mux[STAT_OVERFLOW] = overflow_q;
                rdata_mux[STAT_COUNT_LSB +: COUNT_FIELD_W] = count_ext;
            end
        endcase
    end

    assign iomem_rdata = ready_q ? rdata_mux : 32'd0;

    always_comb begin
        // Ack is a single-cycle pulse; the cycle after it always drops.
        ready_d    = iomem_valid && !ready_q;
        run_d      = run_q;
        ena_d      = ena_q;
        thr_d      = thr_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        dac_d      = dac_q;
        dac_ena_d  = ena_q;
        irq_d      = run_q && count_at_or_below(count_ext, thr_q);

        if (wr_ctrl) begin
            run_d = iomem_wdata[CTRL_RUN];
            ena_d = iomem_wdata[CTRL_ENA];
            thr_d = iomem_wdata[CTRL_THR_LSB +: THR_W];
        end
        if (wr_div) div_d = iomem_wdata[DIV_BITS-1:0];

        // Stopped timer tracks DIV so the first tick lands DIV+1 cycles after run.
        if (!run_q)              cnt_d = div_q;
        else if (cnt_q == '0)    cnt_d = div_q;
        else                     cnt_d = cnt_q - 1'b1;

        // Flag clears come first so a same-cycle event still sets the flag.
        if (wr_stat && iomem_wdata[STAT_UNDERRUN]) underrun_d = 1'b0;
        if (wr_stat && iomem_wdata[STAT_OVERFLOW]) overflow_d = 1'b0;
        if (tick && fifo_empty)                    underrun_d = 1'b1;
        if (wr_data && fifo_full && !pop)          overflow_d = 1'b1;

        if (pop) dac_d = fifo_head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            run_q      <= 1'b0;
            ena_q      <= 1'b0;
            thr_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            dac_q      <= '0;
            dac_ena_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            run_q      <= run_d;
            ena_q      <= ena_d;
            thr_q      <= thr_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            dac_q      <= dac_d;
            dac_ena_q  <= dac_ena_d;
            irq_q      <= irq_d;
        end
    end

    assign iomem_ready = ready_q;
    assign dac_value   = dac_q;
    assign dac_ena     = dac_ena_q;
    assign irq_low     = irq_q;

endmodule

// File: tb/tb_raven_dac_streamer.sv
// Directed bench for raven_dac_streamer with a sample scoreboard.
module tb_raven_dac_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [3:0]  iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [9:0]  dac_value;
    logic        dac_ena;
    logic        irq_low;

    int n_assert = 0;
    int n_fail   = 0;

    // Samples expected on dac_value, oldest first (models FIFO contents).
    logic [9:0] exp_q [$];

    localparam logic [3:0] A_CTRL = 4'h0;
    localparam logic [3:0] A_DIV  = 4'h4;
    localparam logic [3:0] A_DATA = 4'h8;
    localparam logic [3:0] A_STAT = 4'hC;

    always #5 clk = ~clk;

    raven_dac_streamer #(
        .DEPTH    (16),
        .DAC_BITS (10),
        .DIV_BITS (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .dac_value   (dac_value),
        .dac_ena     (dac_ena),
        .irq_low     (irq_low)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access: request at a negedge, hold until ready is seen, then
    // release after the acknowledge edge has passed.
    task automatic bus(input logic [3:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, output logic [31:0] rd);
        int waited;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!iomem_ready && waited < 8);
        if (!iomem_ready) check("bus_timeout", {31'b0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check("ready_pulse", {31'b0, iomem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus(addr, 4'hF, data, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus(addr, 4'h0, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic push_sample(input logic [9:0] v);
        if (exp_q.size() < 16) exp_q.push_back(v);
        wr(A_DATA, {22'b0, v});
    endtask

    task automatic check_pop(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        check(tag, {22'b0, dac_value}, {22'b0, e});
    endtask

    initial begin
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 4'h0;
        iomem_wdata = 32'd0;

        // ---- 1: reset state
        wait_n(3);
        check("rst_dac",   {22'b0, dac_value},  32'd0);
        check("rst_ena",   {31'b0, dac_ena},    32'd0);
        check("rst_irq",   {31'b0, irq_low},    32'd0);
        check("rst_ready", {31'b0, iomem_ready}, 32'd0);
        reset = 1'b0;
        rd_chk("rst_stat", A_STAT, 32'h001);
        rd_chk("rst_ctrl", A_CTRL, 32'h000);
        rd_chk("rst_div",  A_DIV,  32'h000);

        // ---- 2: three samples at a 10-cycle period, then underrun
        wr(A_DIV, 32'd9);
        push_sample(10'h3FF);
        push_sample(10'h200);
        push_sample(10'h001);
        rd_chk("t2_stat3", A_STAT, 32'h0300);
        wr(A_CTRL, 32'h5);                 // run + dac_ena
        wait_n(9);
        check("t2_hold0", {22'b0, dac_value}, 32'd0);
        wait_n(1);
        check_pop("t2_s0");
        wait_n(9);
        check("t2_hold1", {22'b0, dac_value}, 32'h3FF);
        wait_n(1);
        check_pop("t2_s1");
        wait_n(10);
        check_pop("t2_s2");
        check("t2_ena", {31'b0, dac_ena}, 32'd1);
        rd_chk("t2_empty", A_STAT, 32'h001);
        wait_n(8);
        rd_chk("t2_underrun", A_STAT, 32'h005);
        check("t2_dac_hold", {22'b0, dac_value}, 32'h001);
        check("t2_irq", {31'b0, irq_low}, 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h4);
        rd_chk("t2_clr", A_STAT, 32'h001);

        // ---- 3: overfill with run=0
        for (int i = 0; i < 17; i++) push_sample(10'h100 + 10'(i));
        rd_chk("t3_full", A_STAT, 32'h100A);
        check("t3_dac", {22'b0, dac_value}, 32'h001);

        // ---- 4: push on a tick while full
        wr(A_STAT, 32'h8);
        rd_chk("t4_clr", A_STAT, 32'h1002);
        wr(A_DIV, 32'd7);
        wr(A_CTRL, 32'h1);
        wait_n(6);
        iomem_valid = 1'b1;
        iomem_addr  = A_DATA;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h2AA;
        @(negedge clk);
        check("t4_ack", {31'b0, iomem_ready}, 32'd1);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check_pop("t4_pop");
        exp_q.push_back(10'h2AA);
        rd_chk("t4_stat", A_STAT, 32'h1002);
        wr(A_CTRL, 32'h0);
        // drain at one sample per cycle; 0x110 must never appear
        wr(A_DIV, 32'd0);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_pop("t4_drain");
        end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'hC);
        rd_chk("t4_end", A_STAT, 32'h001);

        // ---- 5: FIFO-low interrupt and flush
        wr(A_DIV, 32'd9);
        for (int i = 0; i < 6; i++) push_sample(10'h050 + 10'(i));
        wr(A_CTRL, 32'h405);
        wait_n(10);
        check_pop("t5_s0");
        check("t5_irq_a", {31'b0, irq_low}, 32'd0);
        wait_n(10);
        check_pop("t5_s1");
        check("t5_irq_b", {31'b0, irq_low}, 32'd0);
        wait_n(1);
        check("t5_irq_rise", {31'b0, irq_low}, 32'd1);
        wr(A_CTRL, 32'h407);               // flush
        exp_q.delete();
        rd_chk("t5_flush", A_STAT, 32'h001);
        check("t5_dac", {22'b0, dac_value}, 32'h051);
        rd_chk("t5_ctrl", A_CTRL, 32'h405);
        check("t5_irq_c", {31'b0, irq_low}, 32'd1);

        // ---- 6: reset during a pending DATA write
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_DATA;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h3A5;
        reset       = 1'b1;
        @(negedge clk);
        check("t6_ready_a", {31'b0, iomem_ready}, 32'd0);
        @(negedge clk);
        check("t6_ready_b", {31'b0, iomem_ready}, 32'd0);
        check("t6_dac",     {22'b0, dac_value},  32'd0);
        check("t6_ena",     {31'b0, dac_ena},    32'd0);
        check("t6_irq",     {31'b0, irq_low},    32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        reset       = 1'b0;
        rd_chk("t6_stat", A_STAT, 32'h001);
        rd_chk("t6_ctrl", A_CTRL, 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
